// File: rtl/seg7_display_driver_if.sv
// seg7_display_driver_if
// Groups the value/control inputs and the display outputs of the
// seven-segment driver into one bundle.
//   data_in    : 16-bit value to show as four hex digits
//   load       : capture data_in into the shadow register this cycle
//   blank_lz   : 1 = blank leading zero digits (sampled live)
//   dp_mask    : decimal point enable per digit (sampled live)
//   an         : anodes, active-low, bit i = digit i (digit 0 rightmost)
//   seg        : cathodes {g,f,e,d,c,b,a}, active-low
//   dp         : decimal point, active-low
//   frame_tick : one-cycle pulse on the first lit cycle of digit 0
// The driver uses the slave modport; the value source uses master.
interface seg7_display_driver_if;
  logic [15:0] data_in;
  logic        load;
  logic        blank_lz;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;
  logic        frame_tick;

  modport slave (
    input  data_in, load, blank_lz, dp_mask,
    output an, seg, dp, frame_tick
  );

  modport master (
    output data_in, load, blank_lz, dp_mask,
    input  an, seg, dp, frame_tick
  );
endinterface

// File: rtl/seg7_display_driver.sv
// seg7_display_driver
// Scanned 4-digit seven-segment driver. A value is captured into a shadow
// register on load and copied into the displayed register only at a frame
// boundary, so a digit pattern never tears mid-scan. Each digit is lit for
// REFRESH_DIV cycles (SHOW) followed by BLANK_CYC dark cycles (GAP).
// Ports:
//   clk : system clock
//   rst : asynchronous, active-high reset
//   bus : seg7_display_driver_if.slave (data_in, load, blank_lz, dp_mask in;
//         an, seg, dp, frame_tick out, all outputs registered)
module seg7_display_driver #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  seg7_display_driver_if.slave  bus
);

  localparam int MAX_CYC = (REFRESH_DIV > BLANK_CYC) ? REFRESH_DIV : BLANK_CYC;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] SHOW_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(BLANK_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  typedef enum logic [0:0] {
    ST_GAP  = 1'b0,
    ST_SHOW = 1'b1
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [1:0]       idx_r;
  logic [15:0]      shadow_r;
  logic [15:0]      active_r;
  logic [3:0]       an_r;
  logic [6:0]       seg_r;
  logic             dp_r;
  logic             frame_tick_r;

  logic [3:0]       nibble_s;
  logic             blank_s;
  logic [6:0]       seg_code_s;
  logic [3:0]       an_code_s;
  logic             dp_code_s;

  // Hex nibble to active-low gfedcba pattern.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] code;
    case (nib)
      4'h0:    code = 7'h40;
      4'h1:    code = 7'h79;
      4'h2:    code = 7'h24;
      4'h3:    code = 7'h30;
      4'h4:    code = 7'h19;
      4'h5:    code = 7'h12;
      4'h6:    code = 7'h02;
      4'h7:    code = 7'h78;
      4'h8:    code = 7'h00;
      4'h9:    code = 7'h10;
      4'hA:    code = 7'h08;
      4'hB:    code = 7'h03;
      4'hC:    code = 7'h46;
      4'hD:    code = 7'h21;
      4'hE:    code = 7'h06;
      4'hF:    code = 7'h0E;
      default: code = 7'h7F;
    endcase
    return code;
  endfunction

  // Pattern for the currently selected digit; registered by the scan FSM.
  always_comb begin
    nibble_s = 4'h0;
    blank_s  = 1'b0;
    case (idx_r)
      2'd0: begin
        nibble_s = active_r[3:0];
        blank_s  = 1'b0;  // rightmost digit always shows, even a zero
      end
      2'd1: begin
        nibble_s = active_r[7:4];
        blank_s  = bus.blank_lz && (active_r[15:4] == 12'h000);
      end
      2'd2: begin
        nibble_s = active_r[11:8];
        blank_s  = bus.blank_lz && (active_r[15:8] == 8'h00);
      end
      2'd3: begin
        nibble_s = active_r[15:12];
        blank_s  = bus.blank_lz && (active_r[15:12] == 4'h0);
      end
      default: begin
        nibble_s = 4'h0;
        blank_s  = 1'b0;
      end
    endcase

    if (blank_s) begin
      seg_code_s = 7'h7F;
    end else begin
      seg_code_s = hex_to_seg(nibble_s);
    end

    an_code_s = ~(4'b0001 << idx_r);
    dp_code_s = ~bus.dp_mask[idx_r];
  end

  // Shadow capture; repeated loads within a frame simply overwrite.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_r <= 16'h0000;
    end else if (bus.load) begin
      shadow_r <= bus.data_in;
    end else begin
      shadow_r <= shadow_r;
    end
  end

  // Scan FSM with registered outputs; outputs reflect the previous cycle's
  // state, which keeps them glitch-free and one cycle behind the counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_GAP;
      cnt_r        <= CNT_ZERO;
      idx_r        <= 2'd0;
      active_r     <= 16'h0000;
      an_r         <= 4'hF;
      seg_r        <= 7'h7F;
      dp_r         <= 1'b1;
      frame_tick_r <= 1'b0;
    end else begin
      case (state_r)
        ST_GAP: begin
          an_r         <= 4'hF;
          seg_r        <= 7'h7F;
          dp_r         <= 1'b1;
          frame_tick_r <= 1'b0;
          if (cnt_r == GAP_LAST) begin
            state_r <= ST_SHOW;
            cnt_r   <= CNT_ZERO;
            // The gap before digit 0 is the frame boundary: take the new value.
            if (idx_r == 2'd0) begin
              active_r <= shadow_r;
            end else begin
              active_r <= active_r;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_SHOW: begin
          an_r         <= an_code_s;
          seg_r        <= seg_code_s;
          dp_r         <= dp_code_s;
          frame_tick_r <= (idx_r == 2'd0) && (cnt_r == CNT_ZERO);
          if (cnt_r == SHOW_LAST) begin
            state_r <= ST_GAP;
            cnt_r   <= CNT_ZERO;
            idx_r   <= idx_r + 2'd1;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
          state_r      <= ST_GAP;
          cnt_r        <= CNT_ZERO;
          idx_r        <= 2'd0;
          an_r         <= 4'hF;
          seg_r        <= 7'h7F;
          dp_r         <= 1'b1;
          frame_tick_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.an         = an_r;
  assign bus.seg        = seg_r;
  assign bus.dp         = dp_r;
  assign bus.frame_tick = frame_tick_r;

endmodule

// File: tb/tb_seg7_display_driver.sv
// tb_seg7_display_driver
// Self-checking bench: each scenario task pushes the expected per-cycle
// display pattern of whole frames into a scoreboard queue and pops/compares
// it cycle by cycle once the frame starts.
module tb_seg7_display_driver;
  localparam int RD    = 4;
  localparam int BC    = 2;
  localparam int FRAME = 4 * (RD + BC);

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   errors = 0;
  int   checks = 0;

  seg7_display_driver_if bus ();

  seg7_display_driver #(.REFRESH_DIV(RD), .BLANK_CYC(BC)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       ft;
  } obs_t;

  obs_t sb[$];

  logic [6:0] hex_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Expected outputs for one frame, starting at the first lit cycle of digit 0.
  function automatic void push_frame(input logic [15:0] v, input logic blz, input logic [3:0] mask);
    obs_t o;
    logic [3:0] nib;
    logic blank;
    for (int d = 0; d < 4; d++) begin
      nib = v[4*d +: 4];
      case (d)
        3:       blank = blz && (v[15:12] == 4'h0);
        2:       blank = blz && (v[15:8] == 8'h00);
        1:       blank = blz && (v[15:4] == 12'h000);
        default: blank = 1'b0;
      endcase
      for (int k = 0; k < RD; k++) begin
        o.an  = ~(4'b0001 << d);
        o.seg = blank ? 7'h7F : hex_tab[nib];
        o.dp  = ~mask[d];
        o.ft  = (d == 0) && (k == 0);
        sb.push_back(o);
      end
      for (int k = 0; k < BC; k++) begin
        o.an = 4'hF; o.seg = 7'h7F; o.dp = 1'b1; o.ft = 1'b0;
        sb.push_back(o);
      end
    end
  endfunction

  function automatic obs_t observe();
    return {bus.an, bus.seg, bus.dp, bus.frame_tick};
  endfunction

  task automatic load_word(input logic [15:0] v);
    bus.data_in = v;
    bus.load = 1'b1;
    @(posedge clk);
    #1 bus.load = 1'b0;
  endtask

  task automatic wait_frame(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge clk);
      if (bus.frame_tick === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    obs_t got, exp_o;
    int n;
    bus.load = 1'b0; bus.blank_lz = 1'b0; bus.dp_mask = 4'h0; bus.data_in = 16'h0000;
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++; if (bus.an !== 4'hF) begin errors++; $display("FAIL reset_an: got %h want F", bus.an); end
    checks++; if (bus.seg !== 7'h7F) begin errors++; $display("FAIL reset_seg: got %h want 7F", bus.seg); end
    checks++; if (bus.dp !== 1'b1) begin errors++; $display("FAIL reset_dp: got %b want 1", bus.dp); end
    checks++; if (bus.frame_tick !== 1'b0) begin errors++; $display("FAIL reset_ft: got %b want 0", bus.frame_tick); end
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.an === 4'hE) break;
    end
    checks++; if (n !== BC + 1) begin errors++; $display("FAIL reset_first_lit: edges %0d want %0d", n, BC + 1); end
    push_frame(16'h0000, 1'b0, 4'h0);
    @(negedge clk);
    for (int i = 0; i < FRAME; i++) begin
      exp_o = sb.pop_front(); got = observe(); checks++;
      if (got !== exp_o) begin errors++; $display("FAIL reset_scan c%0d: got %h want %h", i, got, exp_o); end
      @(negedge clk);
    end
  endtask

  task automatic test_hex_decode();
    obs_t got, exp_o;
    bit ok;
    wait_frame(ok);
    bus.blank_lz = 1'b0; bus.dp_mask = 4'h0;
    load_word(16'h12AF);
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL hex_sync: got no frame_tick want pulse"); end
    push_frame(16'h12AF, 1'b0, 4'h0);
    push_frame(16'h12AF, 1'b0, 4'h0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      exp_o = sb.pop_front(); got = observe(); checks++;
      if (got !== exp_o) begin errors++; $display("FAIL hex_decode c%0d: got %h want %h", i, got, exp_o); end
      @(negedge clk);
    end
  endtask

  task automatic test_blank_lz();
    obs_t got, exp_o;
    bit ok;
    logic [15:0] vals [2] = '{16'h0030, 16'h0000};
    for (int t = 0; t < 2; t++) begin
      wait_frame(ok);
      bus.blank_lz = 1'b1;
      load_word(vals[t]);
      wait_frame(ok);
      checks++; if (!ok) begin errors++; $display("FAIL blank_sync: got no frame_tick want pulse"); end
      push_frame(vals[t], 1'b1, 4'h0);
      for (int i = 0; i < FRAME; i++) begin
        exp_o = sb.pop_front(); got = observe(); checks++;
        if (got !== exp_o) begin errors++; $display("FAIL blank_lz v%h c%0d: got %h want %h", vals[t], i, got, exp_o); end
        @(negedge clk);
      end
    end
    bus.blank_lz = 1'b0;
  endtask

  task automatic test_back_to_back();
    obs_t got, exp_o;
    bit ok;
    wait_frame(ok);
    load_word(16'h1234);
    load_word(16'h5678);
    load_word(16'h9ABC);
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL b2b_sync: got no frame_tick want pulse"); end
    push_frame(16'h9ABC, 1'b0, 4'h0);
    for (int i = 0; i < FRAME; i++) begin
      exp_o = sb.pop_front(); got = observe(); checks++;
      if (got !== exp_o) begin errors++; $display("FAIL back_to_back c%0d: got %h want %h", i, got, exp_o); end
      @(negedge clk);
    end
  endtask

  task automatic test_load_boundary();
    obs_t got, exp_o;
    bit ok;
    wait_frame(ok);
    load_word(16'h1111);
    // The copy edge is the clock edge ending cycle FRAME-2 of this frame.
    repeat (FRAME - 2) @(negedge clk);
    load_word(16'h2222);
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL boundary_sync: got no frame_tick want pulse"); end
    push_frame(16'h1111, 1'b0, 4'h0);
    push_frame(16'h2222, 1'b0, 4'h0);
    for (int i = 0; i < 2 * FRAME; i++) begin
      exp_o = sb.pop_front(); got = observe(); checks++;
      if (got !== exp_o) begin errors++; $display("FAIL load_boundary c%0d: got %h want %h", i, got, exp_o); end
      @(negedge clk);
    end
  endtask

  task automatic test_dp();
    obs_t got, exp_o;
    bit ok;
    wait_frame(ok);
    bus.dp_mask = 4'b0101;
    load_word(16'hBEEF);
    wait_frame(ok);
    checks++; if (!ok) begin errors++; $display("FAIL dp_sync: got no frame_tick want pulse"); end
    push_frame(16'hBEEF, 1'b0, 4'b0101);
    for (int i = 0; i < FRAME; i++) begin
      exp_o = sb.pop_front(); got = observe(); checks++;
      if (got !== exp_o) begin errors++; $display("FAIL dp c%0d: got %h want %h", i, got, exp_o); end
      @(negedge clk);
    end
    bus.dp_mask = 4'h0;
  endtask

  task automatic test_async_reset();
    obs_t got, exp_o;
    bit ok;
    bit found;
    int n;
    wait_frame(ok);
    load_word(16'h4321);
    wait_frame(ok);
    found = 1'b0;
    for (int i = 0; i < FRAME; i++) begin
      if (bus.an === 4'hD) begin found = 1'b1; break; end
      @(negedge clk);
    end
    checks++; if (!found) begin errors++; $display("FAIL areset_find: got an=%h want D", bus.an); end
    #1 rst = 1'b1;
    #1;
    checks++; if (bus.an !== 4'hF) begin errors++; $display("FAIL areset_an: got %h want F", bus.an); end
    checks++; if (bus.seg !== 7'h7F) begin errors++; $display("FAIL areset_seg: got %h want 7F", bus.seg); end
    checks++; if (bus.dp !== 1'b1) begin errors++; $display("FAIL areset_dp: got %b want 1", bus.dp); end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      n++;
      if (bus.an === 4'hE) break;
    end
    checks++; if (n !== BC + 1) begin errors++; $display("FAIL areset_restart: edges %0d want %0d", n, BC + 1); end
    push_frame(16'h0000, 1'b0, 4'h0);
    @(negedge clk);
    for (int i = 0; i < FRAME; i++) begin
      exp_o = sb.pop_front(); got = observe(); checks++;
      if (got !== exp_o) begin errors++; $display("FAIL areset_scan c%0d: got %h want %h", i, got, exp_o); end
      @(negedge clk);
    end
  endtask

  initial begin
    bus.load = 1'b0; bus.blank_lz = 1'b0; bus.dp_mask = 4'h0; bus.data_in = 16'h0000;
    test_reset();
    test_hex_decode();
    test_blank_lz();
    test_back_to_back();
    test_load_boundary();
    test_dp();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no completion want finish");
    $fatal(1);
  end
endmodule
